lot_ticket_tx: RTL and testbench
================================

LOT_TICKET_TX -- requirements
Module: lot_ticket_tx

Interface
REQ-001 The block SHALL have parameter GAP, default 1, meaning idle cycles (0..15) inserted after each digit strobe.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port load  input  1  one-cycle strobe capturing ticket into the ticket register.
REQ-005 The block SHALL have port ticket  input  20  five BCD digits, digit 0 (sent first) in [19:16], digit 4 in [3:0].
REQ-006 The block SHALL have port start  input  1  request to transmit the held ticket.
REQ-007 The block SHALL have port abort  input  1  cancel the game in progress.
REQ-008 The block SHALL have port premio_in  input  2  prize code from the checker (00 none, 01 prize 1, 10 prize 2).
REQ-009 The block SHALL have port num  output  4  digit presented to the checker.
REQ-010 The block SHALL have port insere  output  1  one-cycle strobe qualifying num.
REQ-011 The block SHALL have port fim  output  1  one-cycle end-of-ticket strobe.
REQ-012 The block SHALL have port fim_jogo  output  1  one-cycle game-cancel strobe.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 The block SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-015 The block SHALL have port result  output  2  registered premio_in of the last completed ticket.
REQ-016 The block SHALL have port err  output  1  sticky flag: load rejected for a non-BCD digit.
REQ-017 The block SHALL have port sent_count  output  8  tickets completed, wrapping 255->0.
REQ-018 The block SHALL have port win1_count, win2_count  output  8 each  counts of result 01 and 10, saturating at 255.

Function
REQ-019 States SHALL be IDLE, SEND, GAP, FIM, CAPT and RES, with all transitions on the rising edge of clk.
REQ-020 load in IDLE with all five nibbles <=9 SHALL capture ticket, set valid and clear err; any nibble >9 SHALL set err and leave the register and valid unchanged; load outside IDLE SHALL be ignored.
REQ-021 start in IDLE with valid=1 SHALL move to SEND; start with valid=0 or outside IDLE SHALL be ignored; when load and start are both high, load SHALL take effect and start SHALL be ignored.
REQ-022 In SEND, num SHALL equal digit k and insere=1 for exactly one cycle; the block SHALL then spend GAP cycles in GAP with insere=0 and num held (GAP=0 skips GAP), then continue with k+1.
REQ-023 After digit 4 and its gap, FIM SHALL assert fim for one cycle; CAPT SHALL register premio_in at the end of the cycle after fim; RES SHALL assert done for one cycle with result valid, then return to IDLE.
REQ-024 Latency: with start sampled at edge t, digit k SHALL appear at cycle t+1+k*(GAP+1), fim at t+1+5*(GAP+1), and done at fim+2.
REQ-025 In RES, sent_count SHALL increment by 1; win1_count or win2_count SHALL increment when result is 01 or 10 respectively; premio_in=11 SHALL be stored in result without incrementing any win counter.
REQ-026 valid SHALL remain set after a ticket completes, so a repeated start resends the same ticket.
REQ-027 abort in any non-IDLE state SHALL produce a one-cycle fim_jogo on the next cycle, return to IDLE, suppress done and leave all counters and result unchanged.
REQ-028 abort in IDLE SHALL still produce a one-cycle fim_jogo.
REQ-029 abort SHALL have priority over start and load in the same cycle.
REQ-030 insere, fim and fim_jogo SHALL be mutually exclusive in every cycle.

Reset
REQ-031 When reset is asserted, the block SHALL immediately force IDLE, clear valid, and set num=0, insere=0, fim=0, fim_jogo=0, busy=0, done=0, result=00, err=0 and all counters to 0.
REQ-032 reset asserted mid-ticket SHALL abort the ticket without producing a fim_jogo pulse.
REQ-033 After reset deasserts, the first usable edge SHALL be the next rising clk.

Verification
REQ-034 GAP=1: load 0x47019, start at t=0, bench checker returns 01 -> insere at cycles 1,3,5,7,9 with num 4,7,0,1,9; fim at 11; done at 13; result=01; win1_count=1; sent_count=1.
REQ-035 GAP=0: load 0x47519, start, checker returns 10 -> digits on 5 consecutive cycles 1-5, fim at 6, done at 8, result=10, win2_count=1.
REQ-036 load 0x4A019 -> err=1, valid stays 0, following start ignored, busy stays 0; then load 0x12345 -> err=0.
REQ-037 abort asserted during the third digit's GAP -> fim_jogo one cycle, no fim, no done, sent_count unchanged, busy=0 next cycle.
REQ-038 reset pulse between edges mid-SEND -> all outputs zero immediately; start without a new load ignored.
REQ-039 Run 256 tickets with result 01 -> sent_count wraps to 0 and win1_count holds at 255.

Source files
------------

// File: rtl/lot_ticket_tx_if.sv
// Lottery ticket transmitter <-> prize checker bus.
//   num       : digit presented to the checker
//   insere    : one-cycle strobe qualifying num
//   fim       : one-cycle end-of-ticket strobe
//   fim_jogo  : one-cycle game-cancel strobe
//   premio_in : prize code returned by the checker (00 none, 01 prize 1, 10 prize 2)
// master = transmitter side, slave = checker side.
interface lot_ticket_tx_if;
  logic [3:0] num;
  logic       insere;
  logic       fim;
  logic       fim_jogo;
  logic [1:0] premio_in;

  modport master (output num, insere, fim, fim_jogo, input premio_in);
  modport slave  (input num, insere, fim, fim_jogo, output premio_in);
endinterface

// File: rtl/lot_ticket_tx.sv
// Lottery ticket transmitter.
// Holds a five-digit BCD ticket, sends its digits one by one to a prize
// checker, signals end of ticket, captures the returned prize code and
// keeps completed-ticket and prize statistics.
// Ports:
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   load, ticket  : strobe + five BCD digits (digit 0 in [19:16], sent first)
//   start         : transmit the held ticket
//   abort         : cancel the game in progress (fim_jogo on the next cycle)
//   chk           : checker bus (num, insere, fim, fim_jogo out; premio_in in)
//   busy          : high whenever not IDLE
//   done, result  : one-cycle result pulse and registered prize code
//   err           : sticky, set when a load carried a non-BCD digit
//   sent_count    : completed tickets, wrapping
//   win1_count, win2_count : prize 1 / prize 2 results, saturating
module lot_ticket_tx #(
  parameter int GAP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [19:0]           ticket,
  input  logic                  start,
  input  logic                  abort,
  lot_ticket_tx_if.master       chk,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            result,
  output logic                  err,
  output logic [7:0]            sent_count,
  output logic [7:0]            win1_count,
  output logic [7:0]            win2_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_FIM,
    S_CAPT,
    S_RES
  } state_t;

  // Value of the gap counter on the last idle cycle after a digit.
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [19:0] ticket_q;
  logic        valid_q;
  logic [2:0]  idx_q;
  logic [3:0]  gap_q;
  logic [3:0]  num_q;
  logic        fim_jogo_q;
  logic [1:0]  result_q;
  logic        err_q;
  logic [7:0]  sent_q, win1_q, win2_q;

  logic take_load, bad_load, go, next_digit, enter_gap, gap_step, capture;
  logic insere_c, fim_c, done_c;

  function automatic logic is_bcd(input logic [19:0] t);
    return (t[19:16] <= 4'd9) && (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
           (t[7:4] <= 4'd9) && (t[3:0] <= 4'd9);
  endfunction

  function automatic logic [3:0] digit_at(input logic [19:0] t, input logic [2:0] k);
    logic [3:0] d;
    case (k)
      3'd0:    d = t[19:16];
      3'd1:    d = t[15:12];
      3'd2:    d = t[11:8];
      3'd3:    d = t[7:4];
      3'd4:    d = t[3:0];
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and control. Abort overrides everything outside IDLE; in IDLE
  // it simply blocks load and start for that cycle.
  always_comb begin
    state_d    = state_q;
    take_load  = 1'b0;
    bad_load   = 1'b0;
    go         = 1'b0;
    next_digit = 1'b0;
    enter_gap  = 1'b0;
    gap_step   = 1'b0;
    capture    = 1'b0;
    insere_c   = 1'b0;
    fim_c      = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!abort) begin
          if (load) begin
            if (is_bcd(ticket)) take_load = 1'b1;
            else                bad_load  = 1'b1;
          end else if (start && valid_q) begin
            go      = 1'b1;
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        insere_c = 1'b1;
        if (GAP == 0) begin
          if (idx_q == 3'd4) state_d = S_FIM;
          else               next_digit = 1'b1;
        end else begin
          enter_gap = 1'b1;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (idx_q == 3'd4) begin
            state_d = S_FIM;
          end else begin
            next_digit = 1'b1;
            state_d    = S_SEND;
          end
        end else begin
          gap_step = 1'b1;
        end
      end
      S_FIM: begin
        fim_c   = 1'b1;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        capture = 1'b1;
        state_d = S_RES;
      end
      S_RES: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      next_digit = 1'b0;
      enter_gap  = 1'b0;
      gap_step   = 1'b0;
      capture    = 1'b0;
    end
  end

  // Datapath: ticket register, digit sequencing, prize capture and counters.
  // Counters update together with result so they are current while done is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ticket_q   <= 20'd0;
      valid_q    <= 1'b0;
      idx_q      <= 3'd0;
      gap_q      <= 4'd0;
      num_q      <= 4'd0;
      fim_jogo_q <= 1'b0;
      result_q   <= 2'b00;
      err_q      <= 1'b0;
      sent_q     <= 8'd0;
      win1_q     <= 8'd0;
      win2_q     <= 8'd0;
    end else begin
      fim_jogo_q <= abort;
      if (take_load) begin
        ticket_q <= ticket;
        valid_q  <= 1'b1;
        err_q    <= 1'b0;
      end
      if (bad_load) err_q <= 1'b1;
      if (go) begin
        idx_q <= 3'd0;
        num_q <= ticket_q[19:16];
      end
      if (next_digit) begin
        idx_q <= idx_q + 3'd1;
        num_q <= digit_at(ticket_q, idx_q + 3'd1);
      end
      if (enter_gap) gap_q <= 4'd0;
      if (gap_step)  gap_q <= gap_q + 4'd1;
      if (capture) begin
        result_q <= chk.premio_in;
        sent_q   <= sent_q + 8'd1;
        if (chk.premio_in == 2'b01 && win1_q != 8'hFF) win1_q <= win1_q + 8'd1;
        if (chk.premio_in == 2'b10 && win2_q != 8'hFF) win2_q <= win2_q + 8'd1;
      end
    end
  end

  assign chk.num      = num_q;
  assign chk.insere   = insere_c;
  assign chk.fim      = fim_c;
  assign chk.fim_jogo = fim_jogo_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_c;
  assign result       = result_q;
  assign err          = err_q;
  assign sent_count   = sent_q;
  assign win1_count   = win1_q;
  assign win2_count   = win2_q;

endmodule

// File: tb/tb_lot_ticket_tx.sv
// Self-checking bench for lot_ticket_tx: one instance with GAP=1, one with
// GAP=0. Stimulus pushes expected bus events into per-instance queues; the
// monitors pop and compare whenever insere, fim, fim_jogo or done appears.
module tb_lot_ticket_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // GAP=1 instance
  logic        load1, start1, abort1;
  logic [19:0] ticket1;
  logic        busy1, done1, err1;
  logic [1:0]  result1;
  logic [7:0]  sent1, win1a, win2a;
  lot_ticket_tx_if bus1();

  // GAP=0 instance
  logic        load0, start0, abort0;
  logic [19:0] ticket0;
  logic        busy0, done0, err0;
  logic [1:0]  result0;
  logic [7:0]  sent0, win1b, win2b;
  lot_ticket_tx_if bus0();

  lot_ticket_tx #(.GAP(1)) dut1 (
    .clk(clk), .reset(reset), .load(load1), .ticket(ticket1), .start(start1),
    .abort(abort1), .chk(bus1), .busy(busy1), .done(done1), .result(result1),
    .err(err1), .sent_count(sent1), .win1_count(win1a), .win2_count(win2a)
  );

  lot_ticket_tx #(.GAP(0)) dut0 (
    .clk(clk), .reset(reset), .load(load0), .ticket(ticket0), .start(start0),
    .abort(abort0), .chk(bus0), .busy(busy0), .done(done0), .result(result0),
    .err(err0), .sent_count(sent0), .win1_count(win1b), .win2_count(win2b)
  );

  // kind: 0 insere, 1 fim, 2 fim_jogo, 3 done
  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  ev_t q1[$];
  ev_t q0[$];
  int  n_checks = 0;
  int  n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pushEv(input int which, input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    if (which == 1) q1.push_back(e);
    else            q0.push_back(e);
  endtask

  task automatic monEvent(input int which, input int kind, input int val);
    ev_t e;
    n_checks++;
    if ((which == 1 && q1.size() == 0) || (which == 0 && q0.size() == 0)) begin
      n_fail++;
      $display("[TB] FAIL dut%0d unexpected event: got kind=%0d val=%0d cyc=%0d, expected none",
               which, kind, val, cyc);
    end else begin
      if (which == 1) e = q1.pop_front();
      else            e = q0.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_fail++;
        $display("[TB] FAIL dut%0d event: got kind=%0d val=%0d cyc=%0d, expected kind=%0d val=%0d cyc=%0d",
                 which, kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (int'(bus1.insere) + int'(bus1.fim) + int'(bus1.fim_jogo) > 1)
        checkOutput("dut1 strobe exclusivity", 32'd1, 32'd0);
      if (bus1.insere)   monEvent(1, 0, int'(bus1.num));
      if (bus1.fim)      monEvent(1, 1, 0);
      if (bus1.fim_jogo) monEvent(1, 2, 0);
      if (done1)         monEvent(1, 3, int'(result1));
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (int'(bus0.insere) + int'(bus0.fim) + int'(bus0.fim_jogo) > 1)
        checkOutput("dut0 strobe exclusivity", 32'd1, 32'd0);
      if (bus0.insere)   monEvent(0, 0, int'(bus0.num));
      if (bus0.fim)      monEvent(0, 1, 0);
      if (bus0.fim_jogo) monEvent(0, 2, 0);
      if (done0)         monEvent(0, 3, int'(result0));
    end
  end

  function automatic logic busyOf(input int which);
    return (which == 1) ? busy1 : busy0;
  endfunction

  function automatic int qSize(input int which);
    return (which == 1) ? q1.size() : q0.size();
  endfunction

  // One-cycle drive of load/ticket/start/abort on the chosen instance.
  task automatic applyStimulus(input int which, input logic l, input logic [19:0] tk,
                               input logic s, input logic a);
    @(negedge clk);
    if (which == 1) begin
      load1 = l; ticket1 = tk; start1 = s; abort1 = a;
    end else begin
      load0 = l; ticket0 = tk; start0 = s; abort0 = a;
    end
    if (a) pushEv(which, 2, 0, cyc + 1);
    @(negedge clk);
    if (which == 1) begin
      load1 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    end else begin
      load0 = 1'b0; start0 = 1'b0; abort0 = 1'b0;
    end
  endtask

  // Start a full ticket and wait for it to finish. Expected digit k is nibble
  // k counted from the top of the ticket; cycles are relative to the start edge.
  task automatic runTicket(input int which, input int gap, input logic [19:0] tk,
                           input logic [1:0] p, input string name);
    int t0;
    int n;
    @(negedge clk);
    if (which == 1) begin bus1.premio_in = p; start1 = 1'b1; end
    else            begin bus0.premio_in = p; start0 = 1'b1; end
    t0 = cyc;
    for (int k = 0; k < 5; k++)
      pushEv(which, 0, int'((tk >> (16 - 4 * k)) & 20'hF), t0 + 1 + k * (gap + 1));
    pushEv(which, 1, 0, t0 + 1 + 5 * (gap + 1));
    pushEv(which, 3, int'(p), t0 + 3 + 5 * (gap + 1));
    @(negedge clk);
    if (which == 1) start1 = 1'b0;
    else            start0 = 1'b0;
    n = 0;
    while (busyOf(which) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busyOf(which)) checkOutput({name, " timeout"}, 32'd1, 32'd0);
    checkOutput({name, " events drained"}, 32'(qSize(which)), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0;
    reset = 1'b1;
    load1 = 1'b0; start1 = 1'b0; abort1 = 1'b0; ticket1 = 20'd0;
    load0 = 1'b0; start0 = 1'b0; abort0 = 1'b0; ticket0 = 20'd0;
    bus1.premio_in = 2'b00;
    bus0.premio_in = 2'b00;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst num",      32'(bus1.num), 32'd0);
    checkOutput("rst insere",   32'(bus1.insere), 32'd0);
    checkOutput("rst fim",      32'(bus1.fim), 32'd0);
    checkOutput("rst fim_jogo", 32'(bus1.fim_jogo), 32'd0);
    checkOutput("rst busy",     32'(busy1), 32'd0);
    checkOutput("rst done",     32'(done1), 32'd0);
    checkOutput("rst result",   32'(result1), 32'd0);
    checkOutput("rst err",      32'(err1), 32'd0);
    checkOutput("rst sent",     32'(sent1), 32'd0);
    checkOutput("rst win1",     32'(win1a), 32'd0);
    checkOutput("rst win2",     32'(win2a), 32'd0);
    reset = 1'b0;

    // Non-BCD load is rejected, valid stays clear, start ignored
    applyStimulus(1, 1'b1, 20'h4A019, 1'b0, 1'b0);
    checkOutput("bad load err", 32'(err1), 32'd1);
    applyStimulus(1, 1'b0, 20'h0, 1'b1, 1'b0);
    checkOutput("start no valid busy", 32'(busy1), 32'd0);
    @(negedge clk);
    checkOutput("start no valid busy later", 32'(busy1), 32'd0);
    applyStimulus(1, 1'b1, 20'h12345, 1'b0, 1'b0);
    checkOutput("good load clears err", 32'(err1), 32'd0);

    // GAP=0: digits back to back, fim at 6, done at 8
    applyStimulus(0, 1'b1, 20'h47519, 1'b0, 1'b0);
    runTicket(0, 0, 20'h47519, 2'b10, "gap0 ticket");
    checkOutput("gap0 result", 32'(result0), 32'd2);
    checkOutput("gap0 win2",   32'(win2b), 32'd1);
    checkOutput("gap0 win1",   32'(win1b), 32'd0);
    checkOutput("gap0 sent",   32'(sent0), 32'd1);

    // GAP=1: 4,7,0,1,9 on cycles 1,3,5,7,9, fim 11, done 13
    applyStimulus(1, 1'b1, 20'h47019, 1'b0, 1'b0);
    runTicket(1, 1, 20'h47019, 2'b01, "gap1 ticket");
    checkOutput("gap1 result", 32'(result1), 32'd1);
    checkOutput("gap1 win1",   32'(win1a), 32'd1);
    checkOutput("gap1 sent",   32'(sent1), 32'd1);

    // Repeated start resends; code 11 stored without touching win counters
    runTicket(1, 1, 20'h47019, 2'b11, "resend ticket");
    checkOutput("resend result", 32'(result1), 32'd3);
    checkOutput("resend win1",   32'(win1a), 32'd1);
    checkOutput("resend win2",   32'(win2a), 32'd0);
    checkOutput("resend sent",   32'(sent1), 32'd2);

    // Abort during the third digit's gap (cycle 6)
    @(negedge clk);
    bus1.premio_in = 2'b01;
    start1 = 1'b1;
    t0 = cyc;
    pushEv(1, 0, 4, t0 + 1);
    pushEv(1, 0, 7, t0 + 3);
    pushEv(1, 0, 0, t0 + 5);
    @(negedge clk);
    start1 = 1'b0;
    while (cyc < t0 + 6) @(negedge clk);
    abort1 = 1'b1;
    pushEv(1, 2, 0, t0 + 7);
    @(negedge clk);
    abort1 = 1'b0;
    checkOutput("abort busy next cycle", 32'(busy1), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("abort events drained", 32'(q1.size()), 32'd0);
    checkOutput("abort sent unchanged", 32'(sent1), 32'd2);
    checkOutput("abort result unchanged", 32'(result1), 32'd3);

    // Abort in IDLE pulses fim_jogo and overrides load and start
    applyStimulus(1, 1'b1, 20'h12345, 1'b1, 1'b1);
    checkOutput("idle abort busy", 32'(busy1), 32'd0);
    runTicket(1, 1, 20'h47019, 2'b10, "after idle abort");
    checkOutput("after idle abort win2", 32'(win2a), 32'd1);
    checkOutput("after idle abort sent", 32'(sent1), 32'd3);

    // load and start together: load wins, start ignored
    applyStimulus(1, 1'b1, 20'h12345, 1'b1, 1'b0);
    checkOutput("load+start busy", 32'(busy1), 32'd0);
    runTicket(1, 1, 20'h12345, 2'b00, "new ticket");
    checkOutput("new ticket result", 32'(result1), 32'd0);
    checkOutput("new ticket sent",   32'(sent1), 32'd4);
    checkOutput("new ticket win1",   32'(win1a), 32'd1);

    // Reset between edges mid-SEND
    @(negedge clk);
    bus1.premio_in = 2'b01;
    start1 = 1'b1;
    t0 = cyc;
    pushEv(1, 0, 1, t0 + 1);
    @(negedge clk);
    start1 = 1'b0;
    #2 reset = 1'b1;
    #1;
    q1.delete();
    checkOutput("midrst num",      32'(bus1.num), 32'd0);
    checkOutput("midrst insere",   32'(bus1.insere), 32'd0);
    checkOutput("midrst fim_jogo", 32'(bus1.fim_jogo), 32'd0);
    checkOutput("midrst busy",     32'(busy1), 32'd0);
    checkOutput("midrst sent",     32'(sent1), 32'd0);
    checkOutput("midrst win1",     32'(win1a), 32'd0);
    checkOutput("midrst win2",     32'(win2a), 32'd0);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(1, 1'b0, 20'h0, 1'b1, 1'b0);
    checkOutput("start after reset ignored", 32'(busy1), 32'd0);

    // 256 tickets with prize 1: sent wraps, win1 saturates
    applyStimulus(1, 1'b1, 20'h13579, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) runTicket(1, 1, 20'h13579, 2'b01, "wrap ticket");
    checkOutput("wrap sent", 32'(sent1), 32'd0);
    checkOutput("wrap win1", 32'(win1a), 32'd255);
    checkOutput("wrap win2", 32'(win2a), 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
